// File: rtl/rr_mux_arb_pkg.sv
// Shared definitions for the round-robin / fixed-select output mux.
package rr_mux_arb_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int DEFAULT_N = 4;
    localparam int DEFAULT_W = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority encoder: first valid channel at or after ptr_i, modulo N.
module rr_arbiter
    import rr_mux_arb_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    localparam int SW = $clog2(N)
) (
    input  logic [SW-1:0] ptr_i,
    input  logic [N-1:0]  valid_i,
    output logic [SW-1:0] grant_o,
    output logic          grant_valid_o
);

    always_comb begin : search
        int unsigned idx;
        idx           = 0;
        grant_o       = '0;
        grant_valid_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr_i) + k) % N;
            if (!grant_valid_o && valid_i[SW'(idx)]) begin
                grant_o       = SW'(idx);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_arb.sv
// N-channel W-bit selector with fixed or round-robin grant and a single-entry
// registered output stage with valid/ready on every port.
module rr_mux_arb
    import rr_mux_arb_pkg::*;
#(
    parameter  int N  = DEFAULT_N,
    parameter  int W  = DEFAULT_W,
    localparam int SW = $clog2(N)
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N*W-1:0] IN_DATA,
    input  logic [N-1:0]   IN_VALID,
    output logic [N-1:0]   IN_READY,
    input  logic [SW-1:0]  S,
    input  logic           MODE,
    output logic [W-1:0]   O,
    output logic           O_VALID,
    input  logic           O_READY,
    output logic [SW-1:0]  O_SEL
);

    logic [W-1:0]  o_q, o_d;
    logic          o_valid_q, o_valid_d;
    logic [SW-1:0] o_sel_q, o_sel_d;
    logic [SW-1:0] ptr_q, ptr_d;

    logic          load_en;
    logic          rr_mode;
    logic [SW-1:0] rr_grant;
    logic          rr_valid;
    logic          s_in_range;
    logic          fix_valid;
    logic [SW-1:0] grant;
    logic          grant_valid;
    logic          accept;

    rr_arbiter #(.N(N)) u_arb (
        .ptr_i         (ptr_q),
        .valid_i       (IN_VALID),
        .grant_o       (rr_grant),
        .grant_valid_o (rr_valid)
    );

    // With a non-power-of-two N, select codes >= N exist and must never grant.
    if (N == (1 << SW)) begin : g_pow2
        assign s_in_range = 1'b1;
    end else begin : g_npow2
        assign s_in_range = (S < SW'(N));
    end

    assign rr_mode     = (mode_e'(MODE) == MODE_RR);
    assign fix_valid   = s_in_range && IN_VALID[S];
    assign grant       = rr_mode ? rr_grant : S;
    assign grant_valid = rr_mode ? rr_valid : fix_valid;
    assign load_en     = !o_valid_q || O_READY;
    assign accept      = load_en && grant_valid;

    always_comb begin
        IN_READY = '0;
        if (!RST && accept) begin
            IN_READY[grant] = 1'b1;
        end
    end

    always_comb begin
        o_d       = o_q;
        o_sel_d   = o_sel_q;
        o_valid_d = o_valid_q;
        ptr_d     = ptr_q;
        if (load_en) begin
            o_valid_d = grant_valid;
            if (grant_valid) begin
                o_d     = IN_DATA[grant*W +: W];
                o_sel_d = grant;
            end
        end
        if (accept && rr_mode) begin
            ptr_d = (grant == SW'(N - 1)) ? '0 : grant + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_q       <= '0;
            o_valid_q <= 1'b0;
            o_sel_q   <= '0;
            ptr_q     <= '0;
        end else begin
            o_q       <= o_d;
            o_valid_q <= o_valid_d;
            o_sel_q   <= o_sel_d;
            ptr_q     <= ptr_d;
        end
    end

    assign O       = o_q;
    assign O_VALID = o_valid_q;
    assign O_SEL   = o_sel_q;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Scoreboard bench for rr_mux_arb: a behavioural model predicts each transfer and
// IN_READY; accepted words are queued and popped when they appear on O.
module tb_rr_mux_arb;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int SW = 2;

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
    } exp_t;

    logic           CLK;
    logic           RST;
    logic [N*W-1:0] IN_DATA;
    logic [N-1:0]   IN_VALID;
    logic [N-1:0]   IN_READY;
    logic [SW-1:0]  S;
    logic           MODE;
    logic [W-1:0]   O;
    logic           O_VALID;
    logic           O_READY;
    logic [SW-1:0]  O_SEL;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t cur;
    logic ov_m;
    int   ptr_m;

    rr_mux_arb #(.N(N), .W(W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .IN_DATA  (IN_DATA),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .S        (S),
        .MODE     (MODE),
        .O        (O),
        .O_VALID  (O_VALID),
        .O_READY  (O_READY),
        .O_SEL    (O_SEL)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ov_m  = 1'b0;
        ptr_m = 0;
        sb.delete();
        cur.d = '0;
        cur.s = '0;
    endtask

    task automatic model_grant(output int g, output logic gv);
        g  = 0;
        gv = 1'b0;
        if (MODE === 1'b0) begin
            if (int'(S) < N && IN_VALID[S] === 1'b1) begin
                g  = int'(S);
                gv = 1'b1;
            end
        end else begin
            for (int i = ptr_m; i < N; i++)
                if (!gv && IN_VALID[i] === 1'b1) begin g = i; gv = 1'b1; end
            for (int i = 0; i < ptr_m; i++)
                if (!gv && IN_VALID[i] === 1'b1) begin g = i; gv = 1'b1; end
        end
    endtask

    // One clock: check IN_READY mid-cycle, predict, then check outputs after the edge.
    task automatic cycle();
        int         g;
        logic       gv;
        logic       le;
        logic       loaded;
        logic [N-1:0] rdy_exp;
        exp_t       e;
        @(negedge CLK);
        le = !ov_m || (O_READY === 1'b1);
        model_grant(g, gv);
        rdy_exp = '0;
        if (le && gv) rdy_exp[g] = 1'b1;
        check_eq("in_ready", 32'(IN_READY), 32'(rdy_exp));
        loaded = le && gv;
        if (le) begin
            if (gv) begin
                e.d = IN_DATA[g*W +: W];
                e.s = SW'(g);
                sb.push_back(e);
                if (MODE === 1'b1) ptr_m = (g + 1) % N;
            end
            ov_m = gv;
        end
        @(posedge CLK);
        #1;
        check_eq("o_valid", 32'(O_VALID), 32'(ov_m));
        if (loaded && sb.size() > 0) cur = sb.pop_front();
        if (ov_m) begin
            check_eq("o_data", 32'(O), 32'(cur.d));
            check_eq("o_sel", 32'(O_SEL), 32'(cur.s));
        end
    endtask

    logic [W-1:0] exp_fix [4] = '{4'hA, 4'hB, 4'hC, 4'h0};
    int           exp_rr  [6] = '{0, 1, 2, 3, 0, 1};
    logic [W-1:0] exp_rrd [6] = '{4'hA, 4'hB, 4'hC, 4'h0, 4'hA, 4'hB};

    initial begin
        RST      = 1'b0;
        IN_DATA  = 16'h0CBA;
        IN_VALID = 4'b1111;
        S        = '0;
        MODE     = 1'b0;
        O_READY  = 1'b1;
        model_reset();

        // Reset, checked before the first clock edge
        #1 RST = 1'b1;
        #1;
        check_eq("rst_o", 32'(O), 32'h0);
        check_eq("rst_ovalid", 32'(O_VALID), 32'h0);
        check_eq("rst_osel", 32'(O_SEL), 32'h0);
        check_eq("rst_inready", 32'(IN_READY), 32'h0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Fixed select
        MODE = 1'b0;
        for (int s = 0; s < 4; s++) begin
            S = SW'(s);
            cycle();
            check_eq("fix_o", 32'(O), 32'(exp_fix[s]));
            check_eq("fix_sel", 32'(O_SEL), 32'(s));
        end
        IN_DATA[15:12] = 4'bxxxx;
        S = '0;
        cycle();
        check_eq("x_isolation", 32'(O), 32'hA);
        IN_DATA = 16'h0CBA;

        // Round-robin fairness with wrap
        MODE = 1'b1;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (k < 6) begin
                check_eq("rr_sel", 32'(O_SEL), 32'(exp_rr[k]));
                check_eq("rr_o", 32'(O), 32'(exp_rrd[k]));
            end
        end

        // Sparse requests
        IN_VALID = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            cycle();
            check_eq("sparse_sel", 32'(O_SEL), (k % 2 == 0) ? 32'd0 : 32'd2);
        end

        // Backpressure: load channel 1, then stall
        IN_VALID = 4'b0010;
        cycle();
        check_eq("bp_load", 32'(O), 32'hB);
        IN_VALID = 4'b1111;
        O_READY  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check_eq("bp_hold_o", 32'(O), 32'hB);
            check_eq("bp_hold_sel", 32'(O_SEL), 32'd1);
        end
        O_READY = 1'b1;
        cycle();
        check_eq("bp_next_o", 32'(O), 32'hC);
        check_eq("bp_next_sel", 32'(O_SEL), 32'd2);

        // Async reset mid-stall
        O_READY = 1'b0;
        cycle();
        #1 RST = 1'b1;
        #1;
        model_reset();
        check_eq("arst_ovalid", 32'(O_VALID), 32'h0);
        check_eq("arst_o", 32'(O), 32'h0);
        check_eq("arst_inready", 32'(IN_READY), 32'h0);
        #1 RST = 1'b0;
        O_READY = 1'b1;
        cycle();
        check_eq("arst_first_sel", 32'(O_SEL), 32'd0);
        check_eq("arst_first_o", 32'(O), 32'hA);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rr_mux_arb.md
Name: rr_mux_arb

Overview:
- Parametrised N-channel, W-bit selector with a registered output and valid/ready handshakes on every port.
- Generalises the 4-input, 4-bit combinational mux.
- Two modes:
  - Fixed-select: S picks the channel, as in the existing mux.
  - Round-robin: fair arbitration among the channels presenting valid data.
- Sits between multiple producers (e.g. register-file read ports, immediate, PC sources) and a single pipelined consumer.

Parameters:
- N, 4, number of input channels (N >= 2; need not be a power of two).
- W, 4, data width per channel in bits.
- SW, $clog2(N), select/index width; derived localparam, not overridable.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset.
- IN_DATA  input  N*W  channel i occupies bits [i*W+W-1 : i*W].
- IN_VALID  input  N  channel i holds a valid word.
- IN_READY  output  N  channel i's word is accepted this cycle.
- S  input  SW  channel select in fixed mode; ignored in round-robin mode.
- MODE  input  1  0 = fixed-select, 1 = round-robin.
- O  output  W  registered output data.
- O_VALID  output  1  O holds a valid word.
- O_READY  input  1  consumer accepts O this cycle.
- O_SEL  output  SW  index of the channel that supplied O.

Behaviour:
- Clock and reset: one clock, CLK. RST is asynchronous and active-high.
  - While RST=1: O=0, O_VALID=0, O_SEL=0, rr pointer ptr=0, IN_READY=0 (combinational, gated by RST).
  - Reset asserted mid-stall discards the held word.
- Output register is a single-entry stage.
  - load_en = !O_VALID || O_READY.
  - Full throughput: one word per cycle when O_READY is held at 1.
- Grant (combinational):
  - MODE=0: grant = S when S < N and IN_VALID[S]=1; otherwise no grant.
  - S >= N in fixed mode (possible when N is not a power of two) never grants.
  - MODE=1: grant = first i with IN_VALID[i]=1, searching ptr, ptr+1, ..., wrapping modulo N. No grant when IN_VALID=0.
- IN_READY[i] = load_en && grant valid && grant==i. At most one bit is set.
  - A channel must not be required to wait on IN_READY before raising IN_VALID.
- On a clock edge with load_en=1:
  - With a grant: O <= channel data, O_SEL <= grant, O_VALID <= 1.
  - Without a grant: O_VALID <= 0; O and O_SEL hold their last values.
- On a clock edge with load_en=0 (stall): O, O_SEL and O_VALID hold. No IN_READY is asserted.
- Latency: one cycle from accepted input to O_VALID.
- ptr updates only on an accepted transfer in MODE=1: ptr <= (grant+1) mod N, wrapping N-1 -> 0. Otherwise ptr holds.
- In MODE=0, ptr holds its value across fixed-mode use.
- MODE or S changes take effect at the next arbitration. A word already held in O is never altered.
- Simultaneous events are handled in one cycle: consumer drains while a new word loads (O_READY=1, O_VALID=1, grant present).
- Unknown (X) data on a non-granted channel must not propagate to O.

Decomposition:
- Shared package: MODE_FIXED=1'b0, MODE_RR=1'b1, and the default N/W values used across datapath muxes.
- One natural sub-module: rr_arbiter (N, ptr in, IN_VALID in, grant index + grant_valid out), a purely combinational rotate-priority encoder.
- The output register, load logic and ptr update stay in rr_mux_arb.

Test Plan:
1. Reset: RST=1 with all IN_VALID=1 -> O=0, O_VALID=0, O_SEL=0, IN_READY=0000, checked before any clock edge.
2. Fixed mode: MODE=0, IN_DATA={0x0,0xC,0xB,0xA}, IN_VALID=1111, O_READY=1, S=0,1,2,3 on successive cycles -> one cycle later O=0xA,0xB,0xC,0x0 with O_SEL=0,1,2,3; IN_READY one-hot equal to S.
3. Round-robin fairness: MODE=1, IN_VALID=1111 constant, O_READY=1 -> O_SEL sequence 0,1,2,3,0,1 and O sequence A,B,C,0,A,B; wrap 3 -> 0 verified.
4. Sparse requests: MODE=1, IN_VALID=0101 -> O_SEL alternates 0,2,0,2; channels 1 and 3 never get IN_READY.
5. Backpressure: O_VALID=1 holding 0xB, O_READY=0 for 3 cycles -> O=0xB and O_SEL=1 stable, IN_READY=0000, ptr unchanged. Raising O_READY -> next word is channel 2, loaded the same cycle.
6. Async reset mid-stall: RST pulsed between clock edges while O_VALID=1 -> O_VALID=0 and O=0 immediately. After release, the first round-robin grant goes to channel 0.
